fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx_pkg.sv | 23 ++
 rtl/fifo_uart_tx_baud_gen.sv | 42 ++++
 rtl/fifo_uart_tx.sv | 140 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// ----------------------------------------------------------------------------
// fifo_uart_tx_pkg
// Shared definitions for the FIFO-fed UART transmitter.
//   state_e  : 3-bit frame sequencer state encoding
//   cntWidth : width of a counter that has to hold the values 0 .. n-1
// ----------------------------------------------------------------------------
package fifo_uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_e;

    // A counter running 0 .. n-1 needs $clog2(n) bits; a single-value
    // counter still needs one bit to exist at all.
    function automatic int cntWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_gen.sv
// ----------------------------------------------------------------------------
// baud_gen
// Bit-period timer. While clear_i is high the counter is held at zero, so the
// first tick after clear_i drops arrives exactly CLKS_PER_BIT cycles later.
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset
//   clear_i : hold the counter at zero and suppress the tick
//   tick_o  : one-cycle pulse in the last cycle of each bit period
// ----------------------------------------------------------------------------
module baud_gen
    import fifo_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CW = cntWidth(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    // Free-running modulo-CLKS_PER_BIT counter, restarted by clear_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick_o = !clear_i && (cnt_q == CNT_MAX);

endmodule

// File: rtl/fifo_uart_tx.sv
// ----------------------------------------------------------------------------
// fifo_uart_tx
// Pulls words from a show-ahead FIFO and sends each one as an 8N1-style frame
// (start bit, WIDTH data bits LSB first, stop bit) on an idle-high line.
// Ports:
//   clk_i       : clock, rising edge
//   rst_i       : asynchronous active-high reset
//   fifo_data_i : FIFO head word, valid whenever fifo_size_i is nonzero
//   fifo_size_i : FIFO fill level
//   fifo_get_o  : one-cycle pop strobe (asserted during LOAD)
//   enable_i    : allows new frames to start; never aborts a running frame
//   tx_o        : serial output
//   busy_o      : high whenever a frame is in progress (any state but IDLE)
//   done_o      : one-cycle pulse in the last cycle of the stop bit
// ----------------------------------------------------------------------------
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 7,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] fifo_data_i,
    input  logic [DEPTH-1:0] fifo_size_i,
    output logic             fifo_get_o,
    input  logic             enable_i,
    output logic             tx_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int IW = $clog2(WIDTH + 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [IW-1:0]    bitIdx_q;
    logic             armed_q;
    logic             get_q;
    logic             tx_q;
    logic             busy_q;
    logic             tick;
    logic             baudClear;
    logic             canStart;

    // The bit timer only runs while a bit is actually on the line.
    assign baudClear = (state_q == IDLE) || (state_q == LOAD);

    baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (baudClear),
        .tick_o  (tick)
    );

    // armed_q keeps the first LOAD after reset release off the first edge.
    assign canStart = armed_q && enable_i && (fifo_size_i != '0);
    assign shreg_d  = shreg_q >> 1;

    // Frame sequencer. tx/get/busy are registered alongside the state so that
    // they change exactly when the state does and never follow an input
    // combinationally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bitIdx_q <= '0;
            armed_q  <= 1'b0;
            get_q    <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (canStart) begin
                        state_q <= LOAD;
                        get_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    // The FIFO pops on this same edge; the head is captured
                    // first, so later FIFO writes cannot disturb the frame.
                    shreg_q  <= fifo_data_i;
                    bitIdx_q <= '0;
                    get_q    <= 1'b0;
                    tx_q     <= 1'b0;
                    state_q  <= START;
                end
                START: begin
                    if (tick) begin
                        tx_q    <= shreg_q[0];
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bitIdx_q == LAST_BIT) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            shreg_q  <= shreg_d;
                            tx_q     <= shreg_d[0];
                            bitIdx_q <= bitIdx_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (canStart) begin
                            state_q <= LOAD;
                            get_q   <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    get_q   <= 1'b0;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_get_o = get_q;
    assign tx_o       = tx_q;
    assign busy_o     = busy_q;
    assign done_o     = (state_q == STOP) && tick;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// ----------------------------------------------------------------------------
// tb_fifo_uart_tx
// Directed bench for fifo_uart_tx with WIDTH=8, DEPTH=7, CLKS_PER_BIT=4.
// A small show-ahead FIFO model feeds the transmitter; frames are compared
// bit by bit against hand-computed 10-bit line patterns.
// ----------------------------------------------------------------------------
module tb_fifo_uart_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] fifoData;
   logic [6:0] fifoSize;
   logic       fifoGet;
   logic       enable;
   logic       txLine;
   logic       busy;
   logic       done;

   logic       pushReq  = 1'b0;
   logic [7:0] pushData = 8'h00;
   logic [7:0] mem [0:15];
   logic [3:0] rdPtr = 4'd0;
   logic [3:0] wrPtr = 4'd0;
   logic [3:0] diff;
   int         writeCount  = 0;
   int         popCount    = 0;
   int         emptyPopErr = 0;

   int         assertCount = 0;
   int         failCount   = 0;

   typedef struct {
      logic [7:0] data;
      logic [9:0] expBits;
      string      name;
   } vec_t;

   vec_t vecs [6];

   fifo_uart_tx #(
      .WIDTH(8),
      .DEPTH(7),
      .CLKS_PER_BIT(4)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .fifo_data_i (fifoData),
      .fifo_size_i (fifoSize),
      .fifo_get_o  (fifoGet),
      .enable_i    (enable),
      .tx_o        (txLine),
      .busy_o      (busy),
      .done_o      (done)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Show-ahead FIFO model: head word and fill level are visible
   // combinationally, pops and pushes take effect on the rising edge.
   assign diff     = wrPtr - rdPtr;
   assign fifoSize = {3'b000, diff};
   assign fifoData = mem[rdPtr];

   // FIFO storage update plus bookkeeping of pushes, pops and illegal pops.
   always @(posedge clk) begin
      if (pushReq) begin
         mem[wrPtr] <= pushData;
         wrPtr      <= wrPtr + 4'd1;
         writeCount <= writeCount + 1;
      end
      if (fifoGet) begin
         if (diff == 4'd0) begin
            emptyPopErr <= emptyPopErr + 1;
         end else begin
            rdPtr    <= rdPtr + 4'd1;
            popCount <= popCount + 1;
         end
      end
   end

   // One comparison: counts it and reports it when it does not hold.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Writes one word into the FIFO model across one clock edge.
   task automatic applyStimulus(input logic [7:0] data);
      pushData = data;
      pushReq  = 1'b1;
      @(negedge clk);
      pushReq  = 1'b0;
   endtask

   // Waits (bounded) for the pop strobe and checks the LOAD cycle outputs.
   task automatic waitGet(input int budget, input string name);
      int n = 0;
      while (fifoGet !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput($sformatf("%s pop strobe", name), fifoGet, 1);
      checkOutput($sformatf("%s load tx", name), txLine, 1);
      checkOutput($sformatf("%s load busy", name), busy, 1);
   endtask

   // Follows the 40 cycles after LOAD: start, 8 data bits, stop, each 4 cycles.
   task automatic frameCheck(input logic [9:0] expBits, input string name, input int dropAt);
      logic [39:0] obs;
      int busyCycles = 0;
      int getHigh    = 0;
      int donePulses = 0;
      int doneLast   = 0;
      obs = '0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         pushReq = 1'b0;
         if (i == dropAt) enable = 1'b0;
         obs[i] = txLine;
         if (busy === 1'b1) busyCycles++;
         if (fifoGet !== 1'b0) getHigh++;
         if (done === 1'b1) begin
            donePulses++;
            if (i == 39) doneLast++;
         end
      end
      for (int b = 0; b < 10; b++) begin
         checkOutput($sformatf("%s line bit%0d", name, b), obs[4*b +: 4], expBits[b] ? 4'hF : 4'h0);
      end
      checkOutput($sformatf("%s busy cycles", name), busyCycles, 40);
      checkOutput($sformatf("%s pop during frame", name), getHigh, 0);
      checkOutput($sformatf("%s done pulses", name), donePulses, 1);
      checkOutput($sformatf("%s done in last stop cycle", name), doneLast, 1);
   endtask

   // Main sequence: reset, idle with empty FIFO, single frames from the table,
   // then the multi-cycle corner cases.
   initial begin
      int violations;
      int popsBefore;

      // Line patterns in transmit order: bit0 = start, bits1..8 = data LSB
      // first, bit9 = stop.
      vecs[0] = '{8'hA5, 10'b1101001010, "frame A5"};
      vecs[1] = '{8'h3C, 10'b1001111000, "frame 3C"};
      vecs[2] = '{8'h81, 10'b1100000010, "frame 81"};
      vecs[3] = '{8'h00, 10'b1000000000, "frame 00"};
      vecs[4] = '{8'hFF, 10'b1111111110, "frame FF"};
      vecs[5] = '{8'h01, 10'b1000000010, "frame 01"};

      rst    = 1'b1;
      enable = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset tx", txLine, 1);
      checkOutput("reset get", fifoGet, 0);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset done", done, 0);
      rst = 1'b0;

      // Empty FIFO with enable high: nothing may move.
      enable = 1'b1;
      violations = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (fifoGet !== 1'b0 || txLine !== 1'b1 || busy !== 1'b0) violations++;
      end
      checkOutput("empty fifo idle", violations, 0);
      enable = 1'b0;

      // Single frames, one word queued while disabled, then enable raised.
      for (int v = 0; v < 6; v++) begin
         applyStimulus(vecs[v].data);
         enable = 1'b1;
         waitGet(1, vecs[v].name);
         frameCheck(vecs[v].expBits, vecs[v].name, -1);
         @(negedge clk);
         checkOutput($sformatf("%s idle after", vecs[v].name), busy, 0);
         enable = 1'b0;
      end

      // Back-to-back: 00 then FF, five-cycle stop between frames.
      applyStimulus(8'h00);
      applyStimulus(8'hFF);
      enable = 1'b1;
      waitGet(1, "b2b first");
      frameCheck(10'b1000000000, "b2b 00", -1);
      @(negedge clk);
      checkOutput("b2b second pop", fifoGet, 1);
      checkOutput("b2b fifth stop cycle", txLine, 1);
      frameCheck(10'b1111111110, "b2b FF", -1);
      @(negedge clk);
      checkOutput("b2b idle after", busy, 0);
      enable = 1'b0;

      // Enable drop mid-DATA: frame completes, second word waits.
      applyStimulus(8'h3C);
      applyStimulus(8'h11);
      enable = 1'b1;
      waitGet(1, "drop");
      frameCheck(10'b1001111000, "drop 3C", 12);
      @(negedge clk);
      checkOutput("drop idle", busy, 0);
      popsBefore = popCount;
      violations = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (fifoGet !== 1'b0) violations++;
      end
      checkOutput("drop no pop while disabled", violations, 0);
      checkOutput("drop pop count held", popCount, popsBefore);
      checkOutput("drop word still queued", fifoSize, 1);
      enable = 1'b1;
      waitGet(1, "drop resume");
      frameCheck(10'b1000100010, "drop 11", -1);
      @(negedge clk);
      checkOutput("drop idle after", busy, 0);
      enable = 1'b0;

      // Reset during data bit 3 of 0x81 (line low), then send the next word.
      applyStimulus(8'h81);
      applyStimulus(8'h5A);
      enable = 1'b1;
      waitGet(1, "rst");
      repeat (18) @(negedge clk);
      checkOutput("rst line low before reset", txLine, 0);
      rst = 1'b1;
      #1;
      checkOutput("rst async tx", txLine, 1);
      checkOutput("rst async busy", busy, 0);
      checkOutput("rst async get", fifoGet, 0);
      @(negedge clk);
      rst = 1'b0;
      waitGet(6, "rst resume");
      frameCheck(10'b1010110100, "rst 5A", -1);
      @(negedge clk);
      checkOutput("rst idle after", busy, 0);
      enable = 1'b0;

      // Write on the same edge that pops the last queued word.
      applyStimulus(8'h96);
      enable = 1'b1;
      waitGet(1, "concurrent");
      pushData = 8'h69;
      pushReq  = 1'b1;
      frameCheck(10'b1100101100, "concurrent 96", -1);
      @(negedge clk);
      checkOutput("concurrent next pop", fifoGet, 1);
      frameCheck(10'b1011010010, "concurrent 69", -1);
      @(negedge clk);
      checkOutput("concurrent idle after", busy, 0);
      enable = 1'b0;

      checkOutput("pops equal writes", popCount, writeCount);
      checkOutput("no pop from empty fifo", emptyPopErr, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
